dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between NUM_REQ requesters, for example the mem-stage LSU and a program loader or debug port.
- Accepts at most one request per cycle and drives the dmem write_en/mask/addr/data_in directly.
- Registers the read data and returns it to the winning requester one cycle after acceptance.
- Supports round-robin arbitration and fixed-priority arbitration with starvation protection.

Parameters:
- DATA_WIDTH, 32, data and address width.
- MASK_SIZE, DATA_WIDTH/8, byte-enable width.
- NUM_REQ, 2, number of requesters; index 0 is the core LSU.
- MAX_WAIT, 8, in fixed mode, the number of cycles a requester may wait before it is promoted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins) with starvation promotion.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_we  in  NUM_REQ  1 = store, 0 = load.
- req_mask  in  NUM_REQ x MASK_SIZE  byte enables for stores.
- req_addr  in  NUM_REQ x DATA_WIDTH  byte address.
- req_wdata  in  NUM_REQ x DATA_WIDTH  store data.
- rsp_valid  out  NUM_REQ  one-cycle pulse: load data for that requester is on rsp_rdata.
- rsp_rdata  out  DATA_WIDTH  registered load data, shared by all requesters.
- mem_write_en  out  1  to dmem write_en.
- mem_mask  out  MASK_SIZE  to dmem mask.
- mem_addr  out  DATA_WIDTH  to dmem addr.
- mem_wdata  out  DATA_WIDTH  to dmem data_in.
- mem_rdata  in  DATA_WIDTH  from dmem data_out; combinational read of mem_addr.

Behaviour:
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - req_ready is combinational from req_valid, prio_mode and the registered state.
  - At most one bit of req_ready is set per cycle; no bit is set if no request is valid.
  - A requester holds valid and payload stable until it sees ready; the arbiter does not check this.
- Memory side, in the acceptance cycle:
  - mem_addr, mem_mask and mem_wdata come from the granted requester.
  - mem_write_en = req_we[g].
- Memory side, with no grant: mem_write_en = 0 and mem_addr, mem_mask, mem_wdata = 0.
- Load response:
  - On the clock edge after an accepted load, rsp_rdata <= mem_rdata and rsp_valid[g] <= 1 for exactly one cycle.
  - Latency is 1 cycle. There is no backpressure; the requester must take the data.
- Store response: stores produce no response.
  - rsp_rdata keeps its previous value.
  - rsp_valid is 0.
- Throughput: back-to-back acceptances, one per cycle, are allowed from the same or different requesters.
- Round-robin, prio_mode = 0:
  - Register last_g, width clog2(NUM_REQ), resets to NUM_REQ-1.
  - The search starts at last_g+1, modulo NUM_REQ; the first valid requester wins.
  - last_g updates only on a grant.
  - With all requesters continuously valid, each is granted once every NUM_REQ cycles.
- Fixed priority, prio_mode = 1:
  - The lowest valid index wins, unless some valid requester has wait_cnt == MAX_WAIT.
  - In that case the lowest-indexed such requester wins.
  - last_g still tracks the grant, so switching modes stays consistent.
- Wait counters, one per requester, width clog2(MAX_WAIT+1):
  - Increment when valid and not granted, saturating at MAX_WAIT.
  - Clear when granted or when not valid.
  - Counters run in both modes but only affect arbitration in fixed mode.
- A mid-run change of prio_mode takes effect the same cycle and does not clear any state.
- Reset, while rst = 1 and on the edge where it is sampled:
  - req_ready = 0 and mem_write_en = 0.
  - rsp_valid <= 0, rsp_rdata <= 0, last_g <= NUM_REQ-1, all wait_cnt <= 0.
- Reset mid-operation: a pending load response is discarded, so no rsp_valid follows reset. A store presented during the reset cycle is not written.
- No combinational path from mem_rdata to req_ready.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - prio_mode_e, with values ARB_RR and ARB_FIXED.
  - A dmem_req_t struct with fields we, mask, addr, wdata.
  - A helper function for the index width.
- Sub-module rr_pick (combinational):
  - Inputs: valid vector and a start index.
  - Output: one-hot grant, produced by a rotating first-one search.
  - Reused for round-robin (start = last_g+1) and for fixed priority, both the normal search (start = 0) and the starved-mask search (start = 0).

Test Plan:
- Single load: after reset, requester 1 issues a load to addr 0x10 holding 0xDEADBEEF → req_ready[1]=1 in the same cycle; rsp_valid=2'b10 and rsp_rdata=0xDEADBEEF one cycle later.
- Round-robin contention: both requesters hold loads for 6 cycles in prio_mode=0 → grant order 0,1,0,1,0,1; each rsp_valid pulse matches the previous cycle's grant.
- Fixed-priority starvation: prio_mode=1, MAX_WAIT=8, both requesters continuously valid → requester 0 is granted for 8 cycles; requester 1 is granted in cycle 9 (wait_cnt=8); then requester 0 resumes.
- Store path: requester 0 stores 0xA5A5A5A5 with mask 4'b0011 to 0x20, then loads 0x20 → mem_write_en=1 only in the store cycle with mem_mask=0011; the load returns the merged word; no rsp_valid for the store.
- Reset mid-load: assert rst in the cycle after a load is accepted → rsp_valid stays 0; last_g returns to 1; the next simultaneous request is granted to requester 0.
- Idle: no request valid for 10 cycles → req_ready=0, mem_write_en=0, mem_addr=0, rsp_valid=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared types and helpers for the data-memory arbiter.
//   prio_mode_e  : arbitration policy selector (round-robin / fixed priority).
//   dmem_req_t   : one requester's memory command, sized for the default
//                  32-bit data path.
//   idx_width()  : width of an index into n requesters (at least 1 bit).
package dmem_arbiter_pkg;

   localparam int DMEM_DW = 32;
   localparam int DMEM_MW = DMEM_DW / 8;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } prio_mode_e;

   typedef struct packed {
      logic               we;
      logic [DMEM_MW-1:0] mask;
      logic [DMEM_DW-1:0] addr;
      logic [DMEM_DW-1:0] wdata;
   } dmem_req_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotating first-one search. Starting at i_start and
//   wrapping modulo N, the first set bit of i_valid is granted.
//   i_valid [N]  : candidate vector
//   i_start [IW] : first index examined (must be < N)
//   o_grant [N]  : one-hot grant, zero when i_valid is zero
module rr_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_grant
);

   always_comb begin
      int   idx;
      logic found;
      o_grant = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(i_start) + k;
         if (idx >= N) idx = idx - N;
         if (!found && i_valid[idx]) begin
            o_grant[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between NUM_REQ requesters. At most one
//   request is accepted per cycle; the winner drives the memory port
//   directly and, for loads, receives registered read data one cycle later.
//   Round-robin or fixed priority (with starvation promotion) arbitration.
//
//   clk, rst        : clock, synchronous active-high reset
//   prio_mode       : 0 round-robin, 1 fixed priority (lowest index wins)
//   req_valid/ready : per-requester handshake, ready is one-hot or zero
//   req_we/mask/addr/wdata : per-requester command payload
//   rsp_valid       : per-requester one-cycle load-data pulse
//   rsp_rdata       : shared registered load data
//   mem_*           : direct connection to the dmem port
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MASK_SIZE  = DATA_WIDTH / 8,
   parameter int NUM_REQ    = 2,
   parameter int MAX_WAIT   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 prio_mode,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_we,
   input  logic [NUM_REQ-1:0][MASK_SIZE-1:0]    req_mask,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic                                 mem_write_en,
   output logic [MASK_SIZE-1:0]                 mem_mask,
   output logic [DATA_WIDTH-1:0]                mem_addr,
   output logic [DATA_WIDTH-1:0]                mem_wdata,
   input  logic [DATA_WIDTH-1:0]                mem_rdata
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   logic [IW-1:0]      r_last_g;
   logic [CW-1:0]      r_wait [NUM_REQ];
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   logic [IW-1:0]      w_rr_start;
   logic [NUM_REQ-1:0] w_starved;
   logic [NUM_REQ-1:0] w_g_rr;
   logic [NUM_REQ-1:0] w_g_fix;
   logic [NUM_REQ-1:0] w_g_starv;
   logic [NUM_REQ-1:0] w_grant;
   logic [IW-1:0]      w_gidx;
   logic               w_any;
   dmem_req_t          w_sel;

   assign w_rr_start = (r_last_g == LAST_IDX) ? '0 : r_last_g + 1'b1;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         w_starved[i] = req_valid[i] && (r_wait[i] == WAIT_SAT);
   end

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_rr (
      .i_valid (req_valid),
      .i_start (w_rr_start),
      .o_grant (w_g_rr)
   );

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_fix (
      .i_valid (req_valid),
      .i_start ('0),
      .o_grant (w_g_fix)
   );

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_starv (
      .i_valid (w_starved),
      .i_start ('0),
      .o_grant (w_g_starv)
   );

   always_comb begin
      w_grant = '0;
      if (!rst) begin
         if (prio_mode_e'(prio_mode) == ARB_FIXED)
            w_grant = (|w_starved) ? w_g_starv : w_g_fix;
         else
            w_grant = w_g_rr;
      end
   end

   assign w_any     = |w_grant;
   assign req_ready = w_grant;

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_grant[i]) w_gidx = IW'(i);
   end

   always_comb begin
      w_sel = '0;
      if (w_any) begin
         w_sel.we    = req_we[w_gidx];
         w_sel.mask  = req_mask[w_gidx];
         w_sel.addr  = req_addr[w_gidx];
         w_sel.wdata = req_wdata[w_gidx];
      end
   end

   assign mem_write_en = w_sel.we;
   assign mem_mask     = w_sel.mask;
   assign mem_addr     = w_sel.addr;
   assign mem_wdata    = w_sel.wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_g    <= LAST_IDX;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
      end else begin
         r_rsp_valid <= '0;
         if (w_any) begin
            r_last_g <= w_gidx;
            if (!req_we[w_gidx]) begin
               r_rsp_valid[w_gidx] <= 1'b1;
               r_rsp_rdata         <= mem_rdata;
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || w_grant[i])
               r_wait[i] <= '0;
            else if (r_wait[i] != WAIT_SAT)
               r_wait[i] <= r_wait[i] + 1'b1;
         end
      end
   end

   // A response already registered when reset arrives is suppressed so the
   // requester never sees load data that belongs to the pre-reset session.
   assign rsp_valid = r_rsp_valid & ~{NUM_REQ{rst}};
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int MAXW = 8;

   logic                    clk;
   logic                    rst;
   logic                    prio_mode;
   logic [N-1:0]            req_valid;
   logic [N-1:0]            req_ready;
   logic [N-1:0]            req_we;
   logic [N-1:0][MW-1:0]    req_mask;
   logic [N-1:0][DW-1:0]    req_addr;
   logic [N-1:0][DW-1:0]    req_wdata;
   logic [N-1:0]            rsp_valid;
   logic [DW-1:0]           rsp_rdata;
   logic                    mem_write_en;
   logic [MW-1:0]           mem_mask;
   logic [DW-1:0]           mem_addr;
   logic [DW-1:0]           mem_wdata;
   logic [DW-1:0]           mem_rdata;

   dmem_arbiter #(.DATA_WIDTH(DW), .MASK_SIZE(MW), .NUM_REQ(N), .MAX_WAIT(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .prio_mode    (prio_mode),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_mask     (req_mask),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .mem_write_en (mem_write_en),
      .mem_mask     (mem_mask),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Physical memory seen by the DUT: combinational read, byte-masked write.
   logic [DW-1:0] phys [256];
   assign mem_rdata = phys[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_write_en)
         for (int b = 0; b < MW; b++)
            if (mem_mask[b]) phys[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   // Reference model: shadow memory, last winner, per-requester wait counts.
   logic [DW-1:0] shadow [256];
   int m_last = N - 1;
   int m_wait [N];

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;
   rsp_t rspq[$];

   always @(negedge clk) begin
      int g;
      int w;
      logic [N-1:0] exp_rdy;
      rsp_t e;
      if (rst) begin
         check("ready_in_reset", req_ready, '0);
         check("we_in_reset", mem_write_en, 1'b0);
         m_last = N - 1;
         for (int i = 0; i < N; i++) m_wait[i] = 0;
      end else begin
         g = -1;
         if (prio_mode) begin
            for (int i = 0; i < N; i++)
               if (g < 0 && req_valid[i] && m_wait[i] == MAXW) g = i;
            for (int i = 0; i < N; i++)
               if (g < 0 && req_valid[i]) g = i;
         end else begin
            for (int k = 1; k <= N; k++) begin
               w = (m_last + k) % N;
               if (g < 0 && req_valid[w]) g = w;
            end
         end
         exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
         check("req_ready", req_ready, exp_rdy);
         if (g >= 0) begin
            check("mem_addr", mem_addr, req_addr[g]);
            check("mem_write_en", mem_write_en, req_we[g]);
            check("mem_mask", mem_mask, req_mask[g]);
            check("mem_wdata", mem_wdata, req_wdata[g]);
            if (req_we[g]) begin
               for (int b = 0; b < MW; b++)
                  if (req_mask[g][b]) shadow[req_addr[g][9:2]][8*b +: 8] = req_wdata[g][8*b +: 8];
            end else begin
               e.idx  = g;
               e.data = shadow[req_addr[g][9:2]];
               e.due  = cyc + 1;
               rspq.push_back(e);
            end
            m_last = g;
         end else begin
            check("idle_we", mem_write_en, 1'b0);
            check("idle_addr", mem_addr, '0);
            check("idle_mask", mem_mask, '0);
            check("idle_wdata", mem_wdata, '0);
         end
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || i == g) m_wait[i] = 0;
            else if (m_wait[i] < MAXW) m_wait[i] = m_wait[i] + 1;
         end
      end
   end

   // Response monitor: decoupled from stimulus, pops due entries.
   always @(negedge clk) begin
      logic [N-1:0] exp_v;
      logic [DW-1:0] exp_d;
      logic has;
      rsp_t e;
      exp_v = '0;
      exp_d = '0;
      has   = 1'b0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
         e = rspq.pop_front();
         if (!rst) begin
            exp_v = N'(1) << e.idx;
            exp_d = e.data;
            has   = 1'b1;
         end
      end
      check("rsp_valid", rsp_valid, exp_v);
      if (has) check("rsp_rdata", rsp_rdata, exp_d);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_rec(output logic [N-1:0] g);
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      req_valid = '0;
      req_we    = '0;
      req_mask  = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic we, input logic [MW-1:0] m,
                          input logic [DW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_mask[i]  = m;
      req_addr[i]  = a;
      req_wdata[i] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_all();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] rr_exp [6];
      logic [N-1:0] fx_exp [11];

      rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      fx_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                 2'b10, 2'b01, 2'b01};

      for (int i = 0; i < 256; i++) begin
         phys[i]   = $urandom;
         shadow[i] = phys[i];
      end
      phys[4]   = 32'hDEADBEEF;
      shadow[4] = 32'hDEADBEEF;
      phys[8]   = 32'h11223344;
      shadow[8] = 32'h11223344;

      rst       = 1'b1;
      prio_mode = 1'b0;
      idle_all();
      step();
      step();
      @(negedge clk);
      check("reset_rsp_rdata", rsp_rdata, '0);
      step();
      rst = 1'b0;

      // Single load from requester 1.
      set_req(1, 1'b0, 4'hF, 32'h10, 32'h0);
      step_rec(g);
      check("single_load_grant", g, 2'b10);
      idle_all();
      @(negedge clk);
      check("single_load_rsp_valid", rsp_valid, 2'b10);
      check("single_load_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      step();

      // Round-robin contention.
      do_reset();
      prio_mode = 1'b0;
      set_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
      set_req(1, 1'b0, 4'hF, 32'h20, 32'h0);
      for (int c = 0; c < 6; c++) begin
         step_rec(g);
         check("rr_order", g, rr_exp[c]);
      end
      idle_all();
      step();

      // Fixed priority with starvation promotion.
      do_reset();
      prio_mode = 1'b1;
      set_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
      set_req(1, 1'b0, 4'hF, 32'h20, 32'h0);
      for (int c = 0; c < 11; c++) begin
         step_rec(g);
         check("fixed_order", g, fx_exp[c]);
      end
      idle_all();
      step();

      // Store then load of the merged word.
      do_reset();
      prio_mode = 1'b0;
      set_req(0, 1'b1, 4'b0011, 32'h20, 32'hA5A5A5A5);
      step_rec(g);
      check("store_grant", g, 2'b01);
      idle_all();
      set_req(0, 1'b0, 4'hF, 32'h20, 32'h0);
      step_rec(g);
      idle_all();
      @(negedge clk);
      check("merged_rsp_valid", rsp_valid, 2'b01);
      check("merged_rsp_rdata", rsp_rdata, 32'h1122A5A5);
      step();

      // Reset right after a load is accepted.
      do_reset();
      set_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
      step();
      idle_all();
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_rsp_valid", rsp_valid, '0);
      step();
      rst = 1'b0;
      set_req(0, 1'b0, 4'hF, 32'h10, 32'h0);
      set_req(1, 1'b0, 4'hF, 32'h20, 32'h0);
      step_rec(g);
      check("post_reset_grant", g, 2'b01);
      idle_all();
      step();

      // Idle window.
      for (int c = 0; c < 10; c++) step();

      // Randomized traffic; requesters hold payload until accepted.
      for (int c = 0; c < 3000; c++) begin
         step_rec(g);
         rst = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 63) == 0) prio_mode = ~prio_mode;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || g[i]) begin
               if ($urandom_range(0, 99) < 85)
                  set_req(i, 1'($urandom_range(0, 2) == 0), 4'($urandom),
                          {$urandom_range(0, 15), 2'b00}, $urandom);
               else
                  req_valid[i] = 1'b0;
            end
         end
      end
      rst = 1'b0;
      idle_all();
      for (int c = 0; c < 4; c++) step();
      check("queue_drained", rspq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
